// File: rtl/alu_ctrl_seq_if.sv
// Bus between the control sequencer and its neighbours: instruction memory
// read port, ALU function/status lines and register-file selects.
//
// Handshake: the sequencer holds mem_rd=1 with a stable mem_addr until it
// samples mem_ready=1 at a rising clk edge; that edge transfers mem_rdata.
// mem_ready is ignored whenever mem_rd=0. No other signal in this bundle
// carries a handshake.
interface alu_ctrl_seq_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  fsel;
  logic [3:0]  rf_xsel;
  logic [3:0]  rf_ysel;
  logic        rf_we;
  logic [3:0]  rf_wsel;
  logic        cin;
  logic        zin;
  logic        vin;
  logic        sin;
  logic [3:0]  flags;
  logic        halted;

  // Sequencer side
  modport master (
    output mem_addr, mem_rd, fsel, rf_xsel, rf_ysel, rf_we, rf_wsel,
           flags, halted,
    input  mem_rdata, mem_ready, cin, zin, vin, sin
  );

  // Memory / datapath side
  modport slave (
    input  mem_addr, mem_rd, fsel, rf_xsel, rf_ysel, rf_we, rf_wsel,
           flags, halted,
    output mem_rdata, mem_ready, cin, zin, vin, sin
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Fetch/decode/execute control sequencer for the 16-bit datapath.
// Drives ALU function and register-file selects, latches ALU status into
// a {C,Z,V,S} flag register and uses it for conditional relative branches.
// Every output is decoded from registered state only, so the ALU status
// inputs never reach an output combinationally.
module alu_ctrl_seq #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic           clk,
  input  logic           reset,
  alu_ctrl_seq_if.master bus,
  output logic [2:0]     state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_NEG = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_BR  = 4'h8;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;   // {C,Z,V,S}
  // Low for the cycle right after a reset edge so no read is requested
  // while reset is still being applied.
  logic        run_q;
  logic        taken;
  logic [3:0]  op;

  assign op = ir_q[15:12];

  // Branch condition evaluated against the latched flags
  always_comb begin
    taken = 1'b0;
    case (ir_q[11:8])
      4'h0:    taken = 1'b1;
      4'h1:    taken = flags_q[2];
      4'h2:    taken = flags_q[3];
      4'h3:    taken = flags_q[1];
      4'h4:    taken = flags_q[0];
      4'h5:    taken = ~flags_q[2];
      4'h6:    taken = ~flags_q[3];
      4'h7:    taken = ~flags_q[0];
      default: taken = 1'b0;
    endcase
  end

  // Next-state, PC, IR and flag update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH: begin
        if (run_q && bus.mem_ready) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == HALT_OP)                       state_d = S_HALT;
        else if (op >= 4'h1 && op <= 4'h7)       state_d = S_EXEC;
        else if (op == OP_BR)                    state_d = S_BRANCH;
        else                                     state_d = S_FETCH;
      end
      S_EXEC: begin
        flags_d[2] = bus.zin;
        flags_d[0] = bus.sin;
        if (op == OP_ADD) begin
          flags_d[3] = bus.cin;
          flags_d[1] = bus.vin;
        end else if (op == OP_NEG || op == OP_NOT || op == OP_OR) begin
          flags_d[3] = 1'b0;
          flags_d[1] = 1'b0;
        end
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // PC already points past the branch word
        if (taken) pc_d = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= 16'h0000;
      flags_q <= 4'h0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      run_q   <= 1'b1;
    end
  end

  // Outputs decoded from the registers only
  always_comb begin
    bus.mem_addr = pc_q;
    bus.mem_rd   = (state_q == S_FETCH) && run_q;
    bus.fsel     = (state_q == S_EXEC) ? ir_q[14:12] : 3'b000;
    bus.rf_we    = (state_q == S_EXEC);
    bus.rf_xsel  = ir_q[7:4];
    bus.rf_ysel  = ir_q[3:0];
    bus.rf_wsel  = ir_q[11:8];
    bus.flags    = flags_q;
    bus.halted   = (state_q == S_HALT);
    state_o      = state_q;
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed vector table, multi-cycle corner
// sequences (wait states, reset mid-fetch, halt) and random instruction
// streams checked against an instruction-level model.
module tb_alu_ctrl_seq;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_seq_if bus();
  logic [2:0] state_dbg;

  alu_ctrl_seq #(.PC_RESET(16'h0000), .HALT_OP(4'hF)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Scoreboard: expected fetch addresses and model flags
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_pc;
  logic        m_c, m_z, m_v, m_s;

  typedef struct {
    logic [15:0] ins;
    int          waits;
    logic [3:0]  st;         // ALU status {cin,zin,vin,sin}
    logic [15:0] exp_addr;   // next fetch address
    logic [3:0]  exp_flags;  // {C,Z,V,S} after the instruction
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_true(input logic [3:0] cond);
    case (cond)
      4'd0: return 1'b1;
      4'd1: return m_z;
      4'd2: return m_c;
      4'd3: return m_v;
      4'd4: return m_s;
      4'd5: return !m_z;
      4'd6: return !m_c;
      4'd7: return !m_s;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level effect of an ALU op on the flags
  task automatic model_alu(input logic [3:0] op, input logic [3:0] st);
    m_z = st[2];
    m_s = st[0];
    case (op)
      4'd1:             begin m_c = st[3]; m_v = st[1]; end
      4'd3, 4'd4, 4'd5: begin m_c = 1'b0;  m_v = 1'b0;  end
      default: ;
    endcase
  endtask

  // Reset: low for n edges, then released with a stray mem_ready that must
  // be ignored because mem_rd is still low.
  task automatic do_reset(input int n);
    reset = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = 16'($urandom);
    repeat (n) tick();
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_fsel", bus.fsel, 0);
    check("rst_we", bus.rf_we, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_halted", bus.halted, 0);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("post_rst_rd", bus.mem_rd, 1);
    check("post_rst_addr", bus.mem_addr, 16'h0000);
    m_pc = 16'h0000;
    {m_c, m_z, m_v, m_s} = 4'h0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
  endtask

  // Driver + checker for one instruction, entered in a FETCH cycle and
  // returning in the next FETCH cycle (or in HALT).
  task automatic run_instr(input logic [15:0] ins, input int waits, input logic [3:0] st);
    logic [15:0] a;
    logic [3:0]  op;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL exp_q: no expected fetch address at %0t", $time);
      return;
    end
    a = exp_q.pop_front();
    check("fetch_rd", bus.mem_rd, 1);
    check("fetch_addr", bus.mem_addr, a);
    check("fetch_flags", bus.flags, {m_c, m_z, m_v, m_s});
    check("fetch_we", bus.rf_we, 0);
    for (int w = 0; w < waits; w++) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'($urandom);
      tick();
      check("wait_rd", bus.mem_rd, 1);
      check("wait_addr", bus.mem_addr, a);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = ins;
    {bus.cin, bus.zin, bus.vin, bus.sin} = st;
    tick();
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = 16'($urandom);
    check("dec_rd", bus.mem_rd, 0);
    check("dec_we", bus.rf_we, 0);
    check("dec_fsel", bus.fsel, 0);
    op = ins[15:12];
    m_pc = a + 16'd1;
    if (op == 4'hF) begin
      tick();
      check("halt_flag", bus.halted, 1);
      check("halt_rd", bus.mem_rd, 0);
      return;
    end else if (op >= 4'd1 && op <= 4'd7) begin
      tick();
      check("exec_fsel", bus.fsel, op);
      check("exec_xsel", bus.rf_xsel, ins[7:4]);
      check("exec_ysel", bus.rf_ysel, ins[3:0]);
      check("exec_wsel", bus.rf_wsel, ins[11:8]);
      check("exec_we", bus.rf_we, 1);
      check("exec_rd", bus.mem_rd, 0);
      model_alu(op, st);
      tick();
    end else if (op == 4'd8) begin
      tick();
      check("br_rd", bus.mem_rd, 0);
      check("br_we", bus.rf_we, 0);
      check("br_fsel", bus.fsel, 0);
      if (cond_true(ins[11:8])) m_pc = m_pc + 16'(signed'(ins[7:0]));
      tick();
    end else begin
      tick();
    end
    exp_q.push_back(m_pc);
  endtask

  initial begin
    // ins, waits, {c,z,v,s}, next addr, flags after
    tbl[0]  = '{16'h1123, 0, 4'b1100, 16'h0001, 4'b1100}; // ADD R1,R2,R3
    tbl[1]  = '{16'h0000, 0, 4'b0000, 16'h0002, 4'b1100}; // NOP
    tbl[2]  = '{16'h1456, 4, 4'b1010, 16'h0003, 4'b1010}; // ADD, 4 wait states
    tbl[3]  = '{16'h4107, 1, 4'b0001, 16'h0004, 4'b0001}; // NOT clears C,V
    tbl[4]  = '{16'h2123, 0, 4'b1110, 16'h0005, 4'b0100}; // SUB holds C,V
    tbl[5]  = '{16'h81FE, 2, 4'b0000, 16'h0004, 4'b0100}; // BR Z,-2 taken
    tbl[6]  = '{16'h6230, 0, 4'b0000, 16'h0005, 4'b0000}; // MOVX
    tbl[7]  = '{16'h81FE, 0, 4'b0000, 16'h0006, 4'b0000}; // BR Z,-2 not taken
    tbl[8]  = '{16'h80F8, 0, 4'b0000, 16'hFFFF, 4'b0000}; // BR always -8
    tbl[9]  = '{16'h8001, 1, 4'b0000, 16'h0001, 4'b0000}; // BR at FFFF +1 wraps
    tbl[10] = '{16'h5312, 0, 4'b1101, 16'h0002, 4'b0101}; // OR
    tbl[11] = '{16'h9ABC, 0, 4'b1111, 16'h0003, 4'b0101}; // reserved
    tbl[12] = '{16'h7AB5, 0, 4'b1011, 16'h0004, 4'b0001}; // MOVY holds C,V
    tbl[13] = '{16'h3F0E, 3, 4'b0101, 16'h0005, 4'b0101}; // NEG
    tbl[14] = '{16'h8505, 0, 4'b0000, 16'h0006, 4'b0101}; // BR !Z not taken
    tbl[15] = '{16'h8402, 0, 4'b0000, 16'h0009, 4'b0101}; // BR S taken
    tbl[16] = '{16'h88FF, 0, 4'b0000, 16'h000A, 4'b0101}; // BR never

    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0000;
    {bus.cin, bus.zin, bus.vin, bus.sin} = 4'h0;

    do_reset(2);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      run_instr(tbl[i].ins, tbl[i].waits, tbl[i].st);
      check($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_flags", i), bus.flags, tbl[i].exp_flags);
    end

    // Reset while waiting in FETCH
    bus.mem_ready = 1'b0;
    tick();
    tick();
    check("midwait_rd", bus.mem_rd, 1);
    do_reset(1);

    // Random instruction stream (no HALT)
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [15:0] ins;
      op  = 4'($urandom_range(0, 14));
      ins = {op, 12'($urandom)};
      run_instr(ins, int'($urandom_range(0, 3)), 4'($urandom));
    end

    // Halt and stay halted
    run_instr(16'hF000, 1, 4'($urandom));
    for (int k = 0; k < 6; k++) begin
      bus.mem_ready = 1'b1;
      tick();
      check("halt_hold", bus.halted, 1);
      check("halt_hold_rd", bus.mem_rd, 0);
      check("halt_hold_we", bus.rf_we, 0);
    end

    // Reset out of HALT restarts at PC_RESET
    do_reset(2);
    run_instr(16'h1123, 0, 4'b1100);
    check("restart_addr", bus.mem_addr, 16'h0001);
    check("restart_flags", bus.flags, 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Control sequencer for the 16-bit CPU datapath. It is the driving end of the ALU interface: it issues fsel and register-file selects, and consumes the ALU status outputs cin/zin/vin/sin.
- Runs a fetch/decode/execute FSM against a ready-handshaked instruction memory.
- Latches ALU status into a 4-bit flag register and uses it for conditional relative branches.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- HALT_OP, 4'hF, opcode that halts the sequencer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- mem_addr  output  16  instruction address (equals PC).
- mem_rd  output  1  instruction read request.
- mem_rdata  input  16  instruction word, valid when mem_ready=1.
- mem_ready  input  1  memory accepts the read; rdata valid this cycle.
- fsel  output  3  ALU function select.
- rf_xsel  output  4  register driven onto XYBUS.
- rf_ysel  output  4  register driven onto Y.
- rf_we  output  1  register-file write enable for ZBUS.
- rf_wsel  output  4  destination register.
- cin  input  1  ALU carry out.
- zin  input  1  ALU zero.
- vin  input  1  ALU overflow.
- sin  input  1  ALU sign.
- flags  output  4  latched status {C,Z,V,S}.
- halted  output  1  sequencer stopped.

Behaviour:
- Instruction format: [15:12] op, [11:8] rd or cond, [7:4] rs, [3:0] rt; for branches [7:0] is a signed offset.
- Opcodes, each with its fsel:
  - 0 NOP.
  - 1 ADD rd=rs+rt (001).
  - 2 SUB rd=rs-rt (010).
  - 3 NEG rd=-rt (011).
  - 4 NOT rd=~rt (100).
  - 5 OR rd=rs|rt (101).
  - 6 MOVX rd=rs (110).
  - 7 MOVY rd=rt (111).
  - 8 BR cond.
  - 9..E reserved, execute as NOP.
  - HALT_OP halt.
- Reset (reset=0 at a clk edge):
  - State=FETCH, PC=PC_RESET, IR=0, flags=0, halted=0.
  - fsel=000, rf_we=0, mem_rd=0 in the reset cycle.
  - Reset overrides every state, including a pending fetch; mem_rd drops in the cycle after the reset edge.
- FETCH:
  - mem_rd=1 and mem_addr=PC, held stable until mem_ready=1 is sampled.
  - On that edge: IR<=mem_rdata, PC<=PC+1 (wraps 16'hFFFF->16'h0000), next state DECODE.
  - mem_ready while mem_rd=0 is ignored.
- DECODE: no side effects, fsel=000.
  - ALU op -> EXEC.
  - BR -> BRANCH.
  - HALT_OP -> HALT.
  - NOP/reserved -> FETCH.
- EXEC: single cycle.
  - fsel=op code, rf_xsel=rs, rf_ysel=rt, rf_wsel=rd, rf_we=1.
  - At the ending edge, the register file captures ZBUS and the flags update as follows:
    - Z<=zin and S<=sin on every ALU op.
    - C<=cin and V<=vin on ADD only.
    - C, V cleared on NEG/NOT/OR.
    - C, V held on SUB/MOVX/MOVY.
  - Next state FETCH.
- BRANCH: single cycle.
  - cond[11:8]: 0 always, 1 Z, 2 C, 3 V, 4 S, 5 !Z, 6 !C, 7 !S, 8..F never.
  - If taken: PC<=PC+sext(IR[7:0]), where PC already points past the branch; 16-bit wrap.
  - Next state FETCH. Flags unchanged.
- HALT: halted=1, mem_rd=0, rf_we=0; remains there until reset.
- Outside EXEC: fsel=000 and rf_we=0. Selects may hold their last value but are don't-care.
- Latency with zero wait states:
  - NOP: 2 cycles.
  - ALU op and BR: 3 cycles.
  - Each cycle mem_ready is low adds one FETCH cycle.
- All outputs are registered or decoded from the state register only; no combinational path from the ALU flag inputs to any output.

Test Plan:
- Reset low 2 cycles, then high; mem_ready=1 -> mem_rd=1 with mem_addr=0000 on the first cycle after reset; flags=0, halted=0, fsel=000.
- ADD R1,R2,R3 (16'h1123), ALU returns cin=1, zin=1, vin=0, sin=0 -> EXEC cycle 3 shows fsel=001, rf_xsel=2, rf_ysel=3, rf_wsel=1, rf_we=1; then flags=1100, PC=0001.
- mem_ready held low 4 cycles during fetch -> mem_rd and mem_addr stable for 5 cycles; IR latched only on the ready cycle; PC increments once.
- Z=1, BR Z,-2 (16'h81FE) at PC=0005 -> next fetch address 0004. Same with Z=0 -> 0006. BR always at PC=FFFF, offset +1 -> 0001 (wrap).
- NOT after ADD set C=1,V=1 -> C,V read 0. A following SUB with cin=1 -> C stays 0.
- HALT (16'hF000) -> halted=1, mem_rd=0 indefinitely. Reset low while halted, or mid-wait in FETCH -> FETCH restarts at PC_RESET.
